// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60Hz VGA timing with registered syncs, visible flag and per-frame latched resolution window
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       CLK25,
  input  logic       reset,
  input  logic       rez_160x120,
  input  logic       rez_320x240,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       active_area,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       frame_start
);
  localparam logic [9:0] H_MAX  = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_MAX  = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  logic [9:0] h_nxt, v_nxt, w_lim, l_lim;
  logic [1:0] win, win_nxt;
  logic       at_origin;
  always_comb begin
    h_nxt     = (hcount == H_MAX) ? 10'd0 : hcount + 10'd1;
    v_nxt     = (hcount != H_MAX) ? vcount : (vcount == V_MAX) ? 10'd0 : vcount + 10'd1;
    at_origin = (h_nxt == 10'd0) && (v_nxt == 10'd0);
    win_nxt   = at_origin ? {rez_160x120, rez_320x240 & ~rez_160x120} : win;
    w_lim     = win_nxt[1] ? 10'd160 : win_nxt[0] ? 10'd320 : 10'd640;
    l_lim     = win_nxt[1] ? 10'd120 : win_nxt[0] ? 10'd240 : 10'd480;
  end
  always_ff @(posedge CLK25) begin
    if (reset) begin
      hcount      <= H_MAX;
      vcount      <= V_MAX;
      win         <= 2'b00;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      active_area <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      win         <= win_nxt;
      hsync       <= !((h_nxt >= HS_BEG) && (h_nxt <= HS_END));
      vsync       <= !((v_nxt >= VS_BEG) && (v_nxt <= VS_END));
      video_on    <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
      active_area <= (h_nxt < w_lim) && (v_nxt < l_lim);
      frame_start <= at_origin;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed self-checking bench for vga_timing_gen (full-size and shrunken-porch instances)
module tb_vga_timing_gen;
  logic       clk = 1'b0;
  logic       rst_d = 1'b1, r160_d = 1'b0, r320_d = 1'b0;
  logic       hs_d, vs_d, von_d, act_d, fs_d;
  logic [9:0] hc_d, vc_d;
  logic       rst_s = 1'b1, r160_s = 1'b0, r320_s = 1'b0;
  logic       hs_s, vs_s, von_s, act_s, fs_s;
  logic [9:0] hc_s, vc_s;
  int checks = 0;
  int failures = 0;
  always #20 clk = ~clk;
  vga_timing_gen dut_d (
    .CLK25(clk), .reset(rst_d), .rez_160x120(r160_d), .rez_320x240(r320_d),
    .hsync(hs_d), .vsync(vs_d), .video_on(von_d), .active_area(act_d),
    .hcount(hc_d), .vcount(vc_d), .frame_start(fs_d)
  );
  vga_timing_gen #(
    .H_VISIBLE(180), .H_FRONT(8), .H_SYNC(16), .H_BACK(8),
    .V_VISIBLE(130), .V_FRONT(3), .V_SYNC(2), .V_BACK(4)
  ) dut_s (
    .CLK25(clk), .reset(rst_s), .rez_160x120(r160_s), .rez_320x240(r320_s),
    .hsync(hs_s), .vsync(vs_s), .video_on(von_s), .active_area(act_s),
    .hcount(hc_s), .vcount(vc_s), .frame_start(fs_s)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({hc_d, vc_d, hs_d, vs_d, von_d, act_d, fs_d} !== {10'd799, 10'd524, 5'b11000}) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got h=%0d v=%0d hs=%b vs=%b von=%b act=%b fs=%b exp h=799 v=524 hs=1 vs=1 von=0 act=0 fs=0",
                 i, hc_d, vc_d, hs_d, vs_d, von_d, act_d, fs_d);
      end
    end
    rst_d = 1'b0;
    tick();
    checks++;
    if ({hc_d, vc_d, fs_d, von_d, act_d, hs_d, vs_d} !== {20'd0, 5'b11111}) begin
      failures++;
      $display("FAIL first_edge got h=%0d v=%0d fs=%b von=%b act=%b hs=%b vs=%b exp h=0 v=0 all flags 1",
               hc_d, vc_d, fs_d, von_d, act_d, hs_d, vs_d);
    end
  endtask
  task automatic test_hsync_line();
    int hs_low = 0, first_low = -1, last_low = -1, von_n = 0, act_n = 0, fs_n = 0, seq_bad = 0;
    for (int i = 0; i < 800; i++) begin
      if (hc_d !== 10'(i) || vc_d !== 10'd0) seq_bad++;
      if (!hs_d) begin
        hs_low++;
        if (first_low < 0) first_low = i;
        last_low = i;
      end
      von_n += int'(von_d);
      act_n += int'(act_d);
      fs_n  += int'(fs_d);
      tick();
    end
    checks++;
    if (seq_bad !== 0) begin failures++; $display("FAIL hcount_seq got bad=%0d exp 0", seq_bad); end
    checks++;
    if (hs_low !== 96) begin failures++; $display("FAIL hsync_width got %0d exp 96", hs_low); end
    checks++;
    if (first_low !== 656 || last_low !== 751) begin
      failures++;
      $display("FAIL hsync_pos got %0d..%0d exp 656..751", first_low, last_low);
    end
    checks++;
    if (von_n !== 640 || act_n !== 640) begin
      failures++;
      $display("FAIL line_video got von=%0d act=%0d exp 640 640", von_n, act_n);
    end
    checks++;
    if (fs_n !== 1) begin failures++; $display("FAIL line_fs got %0d exp 1", fs_n); end
    checks++;
    if (hc_d !== 10'd0 || vc_d !== 10'd1 || fs_d !== 1'b0) begin
      failures++;
      $display("FAIL vcount_wrap got h=%0d v=%0d fs=%b exp h=0 v=1 fs=0", hc_d, vc_d, fs_d);
    end
  endtask
  task automatic test_priority();
    int act0 = 0, act1 = 0, last_h = -1;
    rst_d = 1'b1; r160_d = 1'b1; r320_d = 1'b1;
    tick();
    rst_d = 1'b0;
    tick();
    for (int i = 0; i < 800; i++) begin
      if (act_d) begin act0++; last_h = int'(hc_d); end
      tick();
    end
    r160_d = 1'b0;
    for (int i = 0; i < 800; i++) begin
      act1 += int'(act_d);
      tick();
    end
    checks++;
    if (act0 !== 160 || last_h !== 159) begin
      failures++;
      $display("FAIL priority_160 got act=%0d last_h=%0d exp 160 159", act0, last_h);
    end
    checks++;
    if (act1 !== 160) begin failures++; $display("FAIL midframe_hold got %0d exp 160", act1); end
  endtask
  task automatic test_window_320();
    int act_n = 0, von_n = 0;
    rst_d = 1'b1; r160_d = 1'b0; r320_d = 1'b1;
    tick();
    rst_d = 1'b0;
    tick();
    for (int i = 0; i < 800; i++) begin
      act_n += int'(act_d);
      von_n += int'(von_d);
      tick();
    end
    checks++;
    if (act_n !== 320 || von_n !== 640) begin
      failures++;
      $display("FAIL window_320 got act=%0d von=%0d exp 320 640", act_n, von_n);
    end
  endtask
  task automatic test_mid_reset();
    rst_d = 1'b1; r320_d = 1'b0;
    tick();
    rst_d = 1'b0;
    tick();
    repeat (1200) tick();
    checks++;
    if (hc_d !== 10'd400 || vc_d !== 10'd1 || hs_d !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_pos got h=%0d v=%0d hs=%b exp 400 1 1", hc_d, vc_d, hs_d);
    end
    rst_d = 1'b1;
    tick();
    checks++;
    if ({hc_d, vc_d, hs_d, vs_d, von_d, act_d, fs_d} !== {10'd799, 10'd524, 5'b11000}) begin
      failures++;
      $display("FAIL mid_reset got h=%0d v=%0d hs=%b vs=%b von=%b act=%b fs=%b exp 799 524 1 1 0 0 0",
               hc_d, vc_d, hs_d, vs_d, von_d, act_d, fs_d);
    end
    rst_d = 1'b0;
    tick();
    checks++;
    if ({hc_d, vc_d, fs_d, hs_d, vs_d} !== {20'd0, 3'b111}) begin
      failures++;
      $display("FAIL post_reset got h=%0d v=%0d fs=%b hs=%b vs=%b exp 0 0 1 1 1", hc_d, vc_d, fs_d, hs_d, vs_d);
    end
  endtask
  task automatic test_frames();
    int von_n = 0, act_n = 0, vs_low = 0, vs_bad = 0, hs_low = 0, fs_n = 0, outside = 0;
    logic a_corner = 1'b0, a_right = 1'b1, a_below = 1'b1;
    r160_s = 1'b0; r320_s = 1'b0; rst_s = 1'b1;
    tick();
    rst_s = 1'b0;
    tick();
    for (int i = 0; i < 29468; i++) begin
      von_n += int'(von_s);
      act_n += int'(act_s);
      fs_n  += int'(fs_s);
      hs_low += int'(!hs_s);
      if (!vs_s) begin
        vs_low++;
        if (vc_s != 10'd133 && vc_s != 10'd134) vs_bad++;
      end
      tick();
      if (hc_s == 10'd0 && vc_s == 10'd100) r160_s = 1'b1;
    end
    checks++;
    if (von_n !== 23400) begin failures++; $display("FAIL frame_video got %0d exp 23400", von_n); end
    checks++;
    if (act_n !== 29468) begin failures++; $display("FAIL frame1_active got %0d exp 29468", act_n); end
    checks++;
    if (vs_low !== 424 || vs_bad !== 0) begin
      failures++;
      $display("FAIL vsync_low got %0d bad=%0d exp 424 0", vs_low, vs_bad);
    end
    checks++;
    if (hs_low !== 2224) begin failures++; $display("FAIL frame_hsync got %0d exp 2224", hs_low); end
    checks++;
    if (fs_n !== 1) begin failures++; $display("FAIL frame_fs_once got %0d exp 1", fs_n); end
    checks++;
    if (fs_s !== 1'b1 || hc_s !== 10'd0 || vc_s !== 10'd0) begin
      failures++;
      $display("FAIL frame_wrap got h=%0d v=%0d fs=%b exp 0 0 1", hc_s, vc_s, fs_s);
    end
    act_n = 0; von_n = 0;
    for (int i = 0; i < 29468; i++) begin
      act_n += int'(act_s);
      von_n += int'(von_s);
      if (act_s && !(hc_s < 10'd160 && vc_s < 10'd120)) outside++;
      if (hc_s == 10'd159 && vc_s == 10'd119) a_corner = act_s;
      if (hc_s == 10'd160 && vc_s == 10'd0) a_right = act_s;
      if (hc_s == 10'd0 && vc_s == 10'd120) a_below = act_s;
      tick();
    end
    checks++;
    if (act_n !== 19200 || outside !== 0) begin
      failures++;
      $display("FAIL frame2_active got %0d outside=%0d exp 19200 0", act_n, outside);
    end
    checks++;
    if (von_n !== 23400) begin failures++; $display("FAIL frame2_video got %0d exp 23400", von_n); end
    checks++;
    if ({a_corner, a_right, a_below} !== 3'b100) begin
      failures++;
      $display("FAIL window_edges got corner=%b right=%b below=%b exp 1 0 0", a_corner, a_right, a_below);
    end
  endtask
  initial begin
    test_reset();
    test_hsync_line();
    test_priority();
    test_window_320();
    test_mid_reset();
    test_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480 @ 60 Hz VGA timing from the 25 MHz pixel clock.
- Outputs: hsync, vsync, pixel counters, a full-raster visible flag for DAC blanking, and a resolution-windowed active_area.
- active_area is the per-pixel enable for the downstream frame-buffer read address generator, which advances its address whenever active_area is high and clears on vsync low.
- Sits between the clock source and the address generator / RGB output stage.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- CLK25  in  1  25 MHz pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- rez_160x120  in  1  select 160x120 window; has priority over rez_320x240
- rez_320x240  in  1  select 320x240 window
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high inside the full 640x480 visible raster
- active_area  out  1  high inside the selected resolution window; enable to address generator
- hcount  out  10  current pixel column, 0..799
- vcount  out  10  current line, 0..524
- frame_start  out  1  one-cycle pulse when the position is (0,0)

Behaviour:
- Totals: H_TOTAL = sum of H params = 800; V_TOTAL = sum of V params = 525.
- Counters:
  - hcount increments every cycle; it wraps H_TOTAL-1 -> 0.
  - vcount increments only when hcount wraps; it wraps V_TOTAL-1 -> 0.
- Output registration:
  - All outputs are registered.
  - Each cycle, every output is decoded from the next counter values, so all outputs describe the same (hcount, vcount) position in the same cycle. There is zero skew between counters and flags.
- Decode for position (h, v):
  - hsync = 0 iff 656 <= h <= 751 (H_VISIBLE+H_FRONT through H_VISIBLE+H_FRONT+H_SYNC-1).
  - vsync = 0 iff 490 <= v <= 491.
  - video_on = (h < 640) and (v < 480).
  - active_area = (h < W) and (v < H), with W/H taken from the latched window select.
  - frame_start = (h == 0) and (v == 0).
- Window select:
  - rez_160x120 = 1 -> W = 160, H = 120.
  - Else rez_320x240 = 1 -> W = 320, H = 240.
  - Else W = 640, H = 480.
  - Both inputs are sampled into an internal register only on the cycle the next position is (0,0).
  - The frame that starts at that position uses the new window. Mid-frame changes to the inputs have no effect until the next frame start.
- Reset (synchronous, while reset = 1):
  - hcount = 799, vcount = 524.
  - hsync = 1, vsync = 1, video_on = 0, active_area = 0, frame_start = 0.
  - The latched window becomes 640x480.
  - The first rising edge with reset = 0 yields position (0,0): frame_start = 1, video_on = 1, active_area = 1. The window select is sampled on that edge.
- Reset asserted mid-frame: the next edge forces the reset values regardless of position. No partial-line completion.
- Per-frame counts: exactly W*H active_area cycles and 640*480 video_on cycles. vsync is low for 1600 cycles (2 lines), after the last active line. The downstream address therefore reaches W*H before being cleared.
- No combinational path from any input to any output.

Test Plan:
- Reset held 3 cycles, then released -> during reset hcount = 799, vcount = 524, hsync = vsync = 1, active_area = 0. First edge after release: hcount = 0, vcount = 0, frame_start = 1, active_area = 1.
- Free-run one full frame (420000 cycles) at 640x480 -> hsync low for exactly 96 cycles per line, starting at hcount = 656. vsync low while vcount is 490..491, i.e. 1600 cycles. video_on count = 307200. frame_start high exactly once, and again at cycle 420000.
- rez_160x120 = 1 from reset -> active_area count per frame = 19200. active_area is high only for hcount < 160 and vcount < 120. video_on count is unchanged at 307200.
- Both rez_160x120 = 1 and rez_320x240 = 1 -> 160x120 window is used (priority): 19200 active cycles.
- Switch rez_320x240 from 0 to 1 at vcount = 100 -> current frame still has 307200 active cycles. Next frame has 76800 active, with active_area high at (319,239) and low at (320,0) and (0,240).
- Assert reset for 1 cycle at (hcount = 400, vcount = 300) -> next cycle shows the reset values. Following cycle is (0,0) with frame_start = 1. No glitch pulse on hsync or vsync.
